// File: rtl/si570_freq_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : si570_freq_sequencer_pkg
// Brief    : Shared types, Si570 register constants and the B7..B12 packer
//            for the Si570 frequency sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package si570_freq_sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE, MUX, FREEZE, WR_A, WR_B, UNFREEZE, NEWFREQ,
    POLL_RD, POLL_WAIT, DONE, ERR
  } state_t;

  localparam logic [7:0] REG_FREEZE   = 8'd137;
  localparam logic [7:0] REG_CTRL     = 8'd135;
  localparam logic [7:0] REG_HSN1     = 8'd7;
  localparam logic [7:0] REG_RFREQ_LO = 8'd11;
  localparam logic [7:0] FREEZE_DCO   = 8'h10;
  localparam logic [7:0] NEW_FREQ     = 8'h40;
  localparam int         NEW_FREQ_BIT = 6;

  // Element [0] is register 7, element [5] is register 12.
  function automatic logic [5:0][7:0] pack_regs(input logic [2:0]  hs_div,
                                                 input logic [6:0]  n1,
                                                 input logic [37:0] rfreq);
    logic [5:0][7:0] b;
    b[0] = {hs_div, n1[6:2]};
    b[1] = {n1[1:0], rfreq[37:32]};
    b[2] = rfreq[31:24];
    b[3] = rfreq[23:16];
    b[4] = rfreq[15:8];
    b[5] = rfreq[7:0];
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/si570_freq_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : si570_freq_sequencer_if
// Brief    : rv0 request / rv1 read-data ready-valid bus towards i2c_master.
// Revision : 1.0 - initial release
// ============================================================================
interface si570_freq_sequencer_if;

  logic            rv0_valid;
  logic            rv0_ready;
  logic [6:0]      rv0_slave_address;
  logic [7:0]      rv0_reg_address;
  logic [1:0]      rv0_burst_count;
  logic [3:0][7:0] rv0_wdata;
  logic            rv0_rd_wrn;
  logic            rv1_valid;
  logic            rv1_ready;
  logic [3:0][7:0] rv1_rdata;

  // Sequencer side: issues requests, consumes read data.
  modport master (
    output rv0_valid, rv0_slave_address, rv0_reg_address, rv0_burst_count,
           rv0_wdata, rv0_rd_wrn, rv1_ready,
    input  rv0_ready, rv1_valid, rv1_rdata
  );

  // i2c_master side.
  modport slave (
    input  rv0_valid, rv0_slave_address, rv0_reg_address, rv0_burst_count,
           rv0_wdata, rv0_rd_wrn, rv1_ready,
    output rv0_ready, rv1_valid, rv1_rdata
  );

endinterface
`default_nettype wire

// File: rtl/si570_freq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : si570_freq_sequencer
// Brief    : Programs a new HS_DIV/N1/RFREQ triple into the Si570 through the
//            PCA9548 mux, then polls NewFreq until the part clears it.
// Revision : 1.0 - initial release
// ============================================================================
module si570_freq_sequencer
  import si570_freq_sequencer_pkg::*;
#(
  parameter logic [6:0] MuxAddr    = 7'h74,
  parameter logic [7:0] MuxChannel = 8'h01,
  parameter logic [6:0] ClkAddr    = 7'h5D,
  parameter int         PollMax    = 255
) (
  input  wire logic         i_clk,
  input  wire logic         i_rst_n,
  input  wire logic         i_start,
  input  wire logic [2:0]   i_hs_div,
  input  wire logic [6:0]   i_n1,
  input  wire logic [37:0]  i_rfreq,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  si570_freq_sequencer_if.master bus
);

  localparam int CntW = $clog2(PollMax + 1);

  typedef struct packed {
    logic [6:0]      slave_address;
    logic [7:0]      reg_address;
    logic [1:0]      burst_count;
    logic [3:0][7:0] wdata;
    logic            rd_wrn;
  } req_t;

  state_t          state;
  logic [2:0]      hs_div;
  logic [6:0]      n1;
  logic [37:0]     rfreq;
  logic [CntW-1:0] poll_cnt;
  req_t            req;
  logic            req_valid;
  logic            rd_ready;
  logic [5:0][7:0] regs;

  assign regs = pack_regs(hs_div, n1, rfreq);

  assign bus.rv0_valid         = req_valid;
  assign bus.rv0_slave_address = req.slave_address;
  assign bus.rv0_reg_address   = req.reg_address;
  assign bus.rv0_burst_count   = req.burst_count;
  assign bus.rv0_wdata         = req.wdata;
  assign bus.rv0_rd_wrn        = req.rd_wrn;
  assign bus.rv1_ready         = rd_ready;

  // Request payload for each request-issuing state.
  function automatic req_t req_for(input state_t s, input logic [5:0][7:0] b);
    req_t r;
    r               = '0;
    r.slave_address = ClkAddr;
    case (s)
      MUX: begin
        // PCA9548 treats both the "register" byte and the data byte as control.
        r.slave_address = MuxAddr;
        r.reg_address   = MuxChannel;
        r.wdata[0]      = MuxChannel;
      end
      FREEZE: begin
        r.reg_address = REG_FREEZE;
        r.wdata[0]    = FREEZE_DCO;
      end
      WR_A: begin
        r.reg_address = REG_HSN1;
        r.burst_count = 2'd3;
        r.wdata       = {b[3], b[2], b[1], b[0]};
      end
      WR_B: begin
        r.reg_address = REG_RFREQ_LO;
        r.burst_count = 2'd1;
        r.wdata       = {16'h0000, b[5], b[4]};
      end
      UNFREEZE: r.reg_address = REG_FREEZE;
      NEWFREQ: begin
        r.reg_address = REG_CTRL;
        r.wdata[0]    = NEW_FREQ;
      end
      POLL_RD: begin
        r.reg_address = REG_CTRL;
        r.rd_wrn      = 1'b1;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Successor of each request state once its rv0 transfer happens.
  function automatic state_t next_state(input state_t s);
    case (s)
      MUX:      return FREEZE;
      FREEZE:   return WR_A;
      WR_A:     return WR_B;
      WR_B:     return UNFREEZE;
      UNFREEZE: return NEWFREQ;
      NEWFREQ:  return POLL_RD;
      POLL_RD:  return POLL_WAIT;
      default:  return IDLE;
    endcase
  endfunction

  // Sequencer FSM: start latch, one request per state, NewFreq poll decision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      hs_div    <= '0;
      n1        <= '0;
      rfreq     <= '0;
      poll_cnt  <= '0;
      req       <= '0;
      req_valid <= 1'b0;
      rd_ready  <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_error   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            hs_div   <= i_hs_div;
            n1       <= i_n1;
            rfreq    <= i_rfreq;
            poll_cnt <= '0;
            o_error  <= 1'b0;
            o_busy   <= 1'b1;
            state    <= MUX;
          end
        end
        MUX, FREEZE, WR_A, WR_B, UNFREEZE, NEWFREQ, POLL_RD: begin
          // Raise the request with its payload, hold it until accepted,
          // then drop valid for a cycle while the next state builds its own.
          if (!req_valid) begin
            req_valid <= 1'b1;
            req       <= req_for(state, regs);
          end else if (bus.rv0_ready) begin
            req_valid <= 1'b0;
            state     <= next_state(state);
            if (state == POLL_RD) begin
              poll_cnt <= poll_cnt + CntW'(1);
              rd_ready <= 1'b1;
            end
          end
        end
        POLL_WAIT: begin
          if (bus.rv1_valid && rd_ready) begin
            rd_ready <= 1'b0;
            if (!bus.rv1_rdata[0][NEW_FREQ_BIT]) begin
              o_done <= 1'b1;
              state  <= DONE;
            end else if (poll_cnt == CntW'(PollMax)) begin
              o_error <= 1'b1;
              state   <= ERR;
            end else begin
              state <= POLL_RD;
            end
          end
        end
        DONE, ERR: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_si570_freq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_si570_freq_sequencer
// Brief    : Self-checking bench; expected request streams are derived from
//            the register map with plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_si570_freq_sequencer;

  localparam int POLL_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  hs_div = '0;
  logic [6:0]  n1 = '0;
  logic [37:0] rfreq = '0;
  logic        busy, done, error;
  int          total = 0;
  int          bad = 0;

  si570_freq_sequencer_if bus();

  si570_freq_sequencer #(.PollMax(POLL_MAX)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_hs_div(hs_div),
    .i_n1    (n1),
    .i_rfreq (rfreq),
    .o_busy  (busy),
    .o_done  (done),
    .o_error (error),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  sa;
    logic [7:0]  ra;
    logic [1:0]  bc;
    logic [31:0] wd;
    logic        rw;
  } req_t;

  req_t expq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic req_t cur_req();
    return '{sa: bus.rv0_slave_address, ra: bus.rv0_reg_address,
             bc: bus.rv0_burst_count, wd: bus.rv0_wdata, rw: bus.rv0_rd_wrn};
  endfunction

  function automatic logic [63:0] all_outputs();
    return {9'd0, busy, done, error, bus.rv0_valid, bus.rv1_ready, cur_req()};
  endfunction

  function automatic void mk(input int sa, input int ra, input int bc,
                             input int w0, input int w1, input int w2, input int w3,
                             input int rw);
    req_t r;
    r.sa = 7'(sa); r.ra = 8'(ra); r.bc = 2'(bc);
    r.wd = {8'(w3), 8'(w2), 8'(w1), 8'(w0)}; r.rw = 1'(rw);
    expq.push_back(r);
  endfunction

  // Register bytes by arithmetic on the requested frequency word.
  function automatic void build_expect(input logic [2:0] hs, input logic [6:0] n,
                                       input logic [37:0] rf, input int n_reads);
    longint rfl;
    int b[6];
    rfl  = longint'(rf);
    b[0] = int'(hs) * 32 + int'(n) / 4;
    b[1] = (int'(n) % 4) * 64 + int'(rfl >> 32);
    for (int k = 2; k < 6; k++) b[k] = int'((rfl >> (8 * (5 - k))) & 255);
    expq.delete();
    mk('h74, 'h01, 0, 'h01, 0, 0, 0, 0);
    mk('h5D, 137, 0, 'h10, 0, 0, 0, 0);
    mk('h5D, 7, 3, b[0], b[1], b[2], b[3], 0);
    mk('h5D, 11, 1, b[4], b[5], 0, 0, 0);
    mk('h5D, 137, 0, 0, 0, 0, 0, 0);
    mk('h5D, 135, 0, 'h40, 0, 0, 0, 0);
    for (int i = 0; i < n_reads; i++) mk('h5D, 135, 0, 0, 0, 0, 0, 1);
  endfunction

  // One programming sequence acting as i2c_master. n_busy = number of polls
  // that still report NewFreq set; hold_idx = request held off for 10 cycles;
  // poke = re-strobe start during FREEZE; abort_idx = request during which
  // reset is asserted.
  task automatic run_seq(input logic [2:0] hs, input logic [6:0] n, input logic [37:0] rf,
                         input int n_busy, input bit rnd, input int hold_idx,
                         input bit poke, input int abort_idx);
    int n_reads, idx, reads_done, done_cnt, hold_left, owed;
    bit finished, poked, want_err, rdy;
    logic [31:0] rsp;
    want_err = (n_busy >= POLL_MAX);
    n_reads  = want_err ? POLL_MAX : n_busy + 1;
    build_expect(hs, n, rf, n_reads);
    idx = 0; reads_done = 0; done_cnt = 0; hold_left = -1; owed = 0;
    finished = 0; poked = 0;
    @(negedge clk);
    start = 1'b1; hs_div = hs; n1 = n; rfreq = rf;
    @(negedge clk);
    start = 1'b0; hs_div = 3'($urandom); n1 = 7'($urandom);
    rfreq = {6'($urandom), 32'($urandom)};
    check("busy_after_start", busy, 1);
    check("error_cleared_on_start", error, 0);
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      if (done) done_cnt++;
      if (!busy) begin
        finished = 1;
      end else begin
        // read-data side
        rsp = $urandom;
        rsp[6] = (reads_done < n_busy);
        bus.rv1_rdata = rsp;
        bus.rv1_valid = (owed > 0) && (!rnd || ($urandom_range(0, 1) == 1));
        if (bus.rv1_valid && bus.rv1_ready) begin
          owed--;
          reads_done++;
        end
        // request side
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (idx == hold_idx && bus.rv0_valid && hold_left < 0) hold_left = 10;
        if (hold_left > 0) begin
          rdy = 1'b0;
          check("hold_valid", bus.rv0_valid, 1);
          check("hold_payload", cur_req(), expq[idx]);
          hold_left--;
        end
        if (idx == abort_idx && bus.rv0_valid) begin
          bus.rv0_ready = 1'b0;
          #2 rst_n = 1'b0;
          #1 check("async_valid_drop", bus.rv0_valid, 0);
          @(negedge clk);
          rst_n = 1'b1;
          bus.rv1_valid = 1'b0;
          @(negedge clk);
          check("outputs_after_abort", all_outputs(), 0);
          return;
        end
        if (poke && idx == 1 && bus.rv0_valid && !poked) begin
          start = 1'b1; hs_div = ~hs; n1 = ~n; rfreq = ~rf;
          poked = 1;
        end else begin
          start = 1'b0;
        end
        bus.rv0_ready = rdy;
        if (bus.rv0_valid && rdy) begin
          if (idx < expq.size()) check($sformatf("req%0d", idx), cur_req(), expq[idx]);
          else check("extra_request", idx, expq.size());
          if (bus.rv0_rd_wrn) owed++;
          idx++;
        end
      end
      @(negedge clk);
    end
    bus.rv0_ready = 1'b0;
    bus.rv1_valid = 1'b0;
    start = 1'b0;
    check("sequence_finished", finished, 1);
    check("request_count", idx, expq.size());
    check("read_count", reads_done, n_reads);
    check("done_pulses", done_cnt, want_err ? 0 : 1);
    check("error_flag", error, want_err);
    repeat (3) @(negedge clk);
    check("error_sticky", error, want_err);
    check("idle_quiet", {busy, done, bus.rv0_valid, bus.rv1_ready}, 0);
  endtask

  initial begin
    bus.rv0_ready = 1'b0;
    bus.rv1_valid = 1'b0;
    bus.rv1_rdata = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", all_outputs(), 0);

    // directed full sequence, immediate ready, first poll clear
    run_seq(3'd0, 7'd7, 38'h02BC0115EE, 0, 1'b0, -1, 1'b0, -1);
    // backpressure during WR_A
    run_seq(3'($urandom), 7'($urandom), {6'($urandom), 32'($urandom)}, 0, 1'b0, 2, 1'b0, -1);
    // two busy polls then clear
    run_seq(3'($urandom), 7'($urandom), {6'($urandom), 32'($urandom)}, 2, 1'b0, -1, 1'b0, -1);
    // NewFreq never clears -> timeout after POLL_MAX reads
    run_seq(3'($urandom), 7'($urandom), {6'($urandom), 32'($urandom)}, 1000, 1'b0, -1, 1'b0, -1);
    // next start clears the error
    run_seq(3'($urandom), 7'($urandom), {6'($urandom), 32'($urandom)}, 1, 1'b1, -1, 1'b0, -1);
    // start strobe while busy is ignored
    run_seq(3'($urandom), 7'($urandom), {6'($urandom), 32'($urandom)}, 0, 1'b0, -1, 1'b1, -1);
    // reset while WR_B waits for ready, then a clean rerun from MUX
    run_seq(3'($urandom), 7'($urandom), {6'($urandom), 32'($urandom)}, 0, 1'b0, -1, 1'b0, 3);
    run_seq(3'($urandom), 7'($urandom), {6'($urandom), 32'($urandom)}, 0, 1'b0, -1, 1'b0, -1);
    // randomized sequences with random handshakes
    for (int t = 0; t < 6; t++)
      run_seq(3'($urandom), 7'($urandom), {6'($urandom), 32'($urandom)},
              $urandom_range(0, 5), 1'b1, -1, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
